// File: rtl/proc8085_pkg.sv
// Shared encodings for the multi-cycle 8085-style core: opcodes, ALU functions, FSM states.
package proc8085_pkg;

  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_MVI    = 5'b00001;
  localparam logic [4:0] OP_MOV_AR = 5'b00010;
  localparam logic [4:0] OP_MOV_RA = 5'b00011;
  localparam logic [4:0] OP_ALU    = 5'b00100;
  localparam logic [4:0] OP_ADI    = 5'b00101;
  localparam logic [4:0] OP_LDA    = 5'b00110;
  localparam logic [4:0] OP_STA    = 5'b00111;
  localparam logic [4:0] OP_JMP    = 5'b01000;
  localparam logic [4:0] OP_JZ     = 5'b01001;
  localparam logic [4:0] OP_JNZ    = 5'b01010;
  localparam logic [4:0] OP_JC     = 5'b01011;
  localparam logic [4:0] OP_JNC    = 5'b01100;
  localparam logic [4:0] OP_HLT    = 5'b11111;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_ADC = 3'b001;
  localparam logic [2:0] FN_SUB = 3'b010;
  localparam logic [2:0] FN_AND = 3'b011;
  localparam logic [2:0] FN_OR  = 3'b100;
  localparam logic [2:0] FN_XOR = 3'b101;
  localparam logic [2:0] FN_CMP = 3'b110;
  localparam logic [2:0] FN_INR = 3'b111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_8085_param.sv
// Combinational ALU for the multi-cycle core; cin doubles as the carry-in for ADC
// and as the pass-through carry for INR, which leaves cy alone.
module alu_8085_param
  import proc8085_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [2:0]        fn,
  output logic [DATA_W-1:0] res,
  output logic              cy_o,
  output logic              z_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, (fn == FN_ADC) & cin};
    // Top bit of the widened difference is the unsigned borrow (a < b).
    diff = {1'b0, a} - {1'b0, b};
    res  = '0;
    cy_o = 1'b0;
    case (fn)
      FN_ADD, FN_ADC: {cy_o, res} = sum;
      FN_SUB, FN_CMP: begin
        res  = diff[DATA_W-1:0];
        cy_o = diff[DATA_W];
      end
      FN_AND: res = a & b;
      FN_OR:  res = a | b;
      FN_XOR: res = a ^ b;
      FN_INR: begin
        res  = a + DATA_W'(1);
        cy_o = cin;
      end
      default: res = '0;
    endcase
    z_o = (res == '0);
  end

endmodule

// File: rtl/processor_8085_multi.sv
// Multi-cycle 8085-style core: FETCH/EXEC/MEM/HALT sequencer with req/ready memory
// handshakes, parametrised data width, PC width and register count.
module processor_8085_multi
  import proc8085_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [7:0]        dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] acc,
  output logic              cy,
  output logic              z,
  output logic              halted,
  output logic              illegal
);

  state_t              state_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [15:0]         ir_reg;
  logic [DATA_W-1:0]   acc_reg;
  logic                cy_reg;
  logic                z_reg;
  logic                illegal_reg;
  logic [DATA_W-1:0]   rf_reg [NREG];

  logic [4:0]          opcode;
  logic [2:0]          rsel;
  logic [7:0]          imm;
  logic [DATA_W-1:0]   rsel_val;
  logic                reg_ok;
  logic                uses_reg;
  logic                known_op;
  logic                illegal_now;
  logic                jump_taken;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   alu_b;
  logic [2:0]          alu_fn;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_cy;
  logic                alu_z;

  assign opcode = ir_reg[15:11];
  assign rsel   = ir_reg[10:8];
  assign imm    = ir_reg[7:0];
  assign reg_ok = ({29'd0, rsel} < NREG);

  always_comb begin
    rsel_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rsel == 3'(i)) rsel_val = rf_reg[i];
    end
  end

  always_comb begin
    uses_reg = (opcode == OP_MVI) || (opcode == OP_MOV_AR) ||
               (opcode == OP_MOV_RA) || (opcode == OP_ALU);
    case (opcode)
      OP_NOP, OP_MVI, OP_MOV_AR, OP_MOV_RA, OP_ALU, OP_ADI, OP_LDA, OP_STA,
      OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC, OP_HLT: known_op = 1'b1;
      default:                                      known_op = 1'b0;
    endcase
    illegal_now = !known_op || (uses_reg && !reg_ok);

    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = z_reg;
      OP_JNZ:  jump_taken = !z_reg;
      OP_JC:   jump_taken = cy_reg;
      OP_JNC:  jump_taken = !cy_reg;
      default: jump_taken = 1'b0;
    endcase

    alu_b    = (opcode == OP_ADI) ? DATA_W'(imm) : rsel_val;
    alu_fn   = (opcode == OP_ADI) ? FN_ADD : imm[2:0];
    rf_we    = (state_reg == EXEC) && !illegal_now &&
               ((opcode == OP_MVI) || (opcode == OP_MOV_RA));
    rf_wdata = (opcode == OP_MVI) ? DATA_W'(imm) : acc_reg;
  end

  alu_8085_param #(.DATA_W(DATA_W)) u_alu (
    .a    (acc_reg),
    .b    (alu_b),
    .cin  (cy_reg),
    .fn   (alu_fn),
    .res  (alu_res),
    .cy_o (alu_cy),
    .z_o  (alu_z)
  );

  for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           rf_reg[gi] <= '0;
      else if (rf_we && (rsel == 3'(gi)))   rf_reg[gi] <= rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      pc_reg      <= '0;
      ir_reg      <= '0;
      acc_reg     <= '0;
      cy_reg      <= 1'b0;
      z_reg       <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem_ready) begin
            ir_reg    <= imem_data;
            pc_reg    <= pc_reg + PC_W'(1);
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          state_reg <= FETCH;
          if (illegal_now) begin
            illegal_reg <= 1'b1;
          end else begin
            case (opcode)
              OP_MOV_AR: acc_reg <= rsel_val;
              OP_ALU, OP_ADI: begin
                if (alu_fn != FN_CMP) acc_reg <= alu_res;
                cy_reg <= alu_cy;
                z_reg  <= alu_z;
              end
              OP_LDA, OP_STA: state_reg <= MEM;
              OP_HLT:         state_reg <= HALT;
              OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
                if (jump_taken) pc_reg <= PC_W'(imm);
              end
              default: ;
            endcase
          end
        end
        MEM: begin
          if (dmem_ready) begin
            if (opcode == OP_LDA) acc_reg <= dmem_rdata;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= HALT;
      endcase
    end
  end

  // Requests are gated by rst_n so they drop the instant reset asserts.
  assign imem_req   = rst_n && (state_reg == FETCH);
  assign dmem_req   = rst_n && (state_reg == MEM);
  assign imem_addr  = pc_reg;
  assign dmem_we    = (opcode == OP_STA);
  assign dmem_addr  = imm;
  assign dmem_wdata = acc_reg;
  assign acc        = acc_reg;
  assign cy         = cy_reg;
  assign z          = z_reg;
  assign halted     = (state_reg == HALT);
  assign illegal    = illegal_reg;

endmodule

// File: tb/tb_processor_8085_multi.sv
// Directed bench for processor_8085_multi with wait-state instruction/data memory models.
module tb_processor_8085_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        dmem_ready;
  logic [7:0]  dmem_rdata;
  logic [7:0]  acc;
  logic        cy;
  logic        z;
  logic        halted;
  logic        illegal;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  int          imem_wait = 0;
  int          dmem_wait = 0;
  int          iw_cnt;
  int          dw_cnt;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  processor_8085_multi #(.DATA_W(8), .PC_W(8), .NREG(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .acc        (acc),
    .cy         (cy),
    .z          (z),
    .halted     (halted),
    .illegal    (illegal)
  );

  // Memories answer after a programmable number of wait cycles per request.
  assign imem_ready = imem_req && (iw_cnt >= imem_wait);
  assign imem_data  = imem[imem_addr];
  assign dmem_ready = dmem_req && (dw_cnt >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iw_cnt <= 0;
      dw_cnt <= 0;
    end else begin
      iw_cnt <= (!imem_req || imem_ready) ? 0 : iw_cnt + 1;
      dw_cnt <= (!dmem_req || dmem_ready) ? 0 : dw_cnt + 1;
      if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end
  end

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem_wait = 0;
    dmem_wait = 0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    hold_reset();
    imem[0] = 16'h0A05;  // MVI 2,0x05
    imem[1] = 16'h1200;  // MOV A,2
    imem[2] = 16'h28FB;  // ADI 0xFB
    imem[3] = 16'hF800;  // HLT
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: imem_req=%b dmem_req=%b expected 0/0", imem_req, dmem_req);
    end
    checks++;
    if (acc !== 8'h00 || cy !== 1'b0 || z !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_state: acc=%h cy=%b z=%b halted=%b illegal=%b expected 00/0/0/0/0",
                         acc, cy, z, halted, illegal);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL reset_first_fetch: req=%b addr=%h expected 1/00", imem_req, imem_addr);
    end
    @(negedge clk);
    cycles(3);
    checks++;
    if (acc !== 8'h05 || cy !== 1'b0 || z !== 1'b0) begin
      errors++; $display("FAIL mov_a_r: acc=%h cy=%b z=%b expected 05/0/0", acc, cy, z);
    end
    cycles(2);
    $display("add chain: acc=%h cy=%b z=%b", acc, cy, z);
    checks++;
    if (acc !== 8'h00 || cy !== 1'b1 || z !== 1'b1) begin
      errors++; $display("FAIL adi_wrap: acc=%h cy=%b z=%b expected 00/1/1", acc, cy, z);
    end
    cycles(2);
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL hlt: halted=%b imem_req=%b expected 1/0", halted, imem_req);
    end
  endtask

  task automatic test_fetch_wait();
    hold_reset();
    imem_wait = 3;
    imem[0] = 16'h2810;  // ADI 0x10
    imem[1] = 16'hF800;  // HLT
    release_reset();
    for (int k = 1; k <= 3; k++) begin
      cycles(1);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
        errors++; $display("FAIL fetch_wait_hold[%0d]: req=%b addr=%h expected 1/00", k, imem_req, imem_addr);
      end
    end
    cycles(1);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 8'h01 || acc !== 8'h00) begin
      errors++; $display("FAIL fetch_wait_exec: req=%b addr=%h acc=%h expected 0/01/00", imem_req, imem_addr, acc);
    end
    cycles(1);
    $display("ADI with 3 fetch waits: acc=%h", acc);
    checks++;
    if (acc !== 8'h10 || cy !== 1'b0 || z !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL fetch_wait_done: acc=%h cy=%b z=%b req=%b expected 10/0/0/1", acc, cy, z, imem_req);
    end
  endtask

  task automatic test_sta_lda();
    hold_reset();
    dmem_wait = 2;
    dmem[8'h20] = 8'h00;
    imem[0] = 16'h2800;  // ADI 0x00 -> z=1
    imem[1] = 16'h09A5;  // MVI 1,0xA5
    imem[2] = 16'h1100;  // MOV A,1
    imem[3] = 16'h3820;  // STA 0x20
    imem[4] = 16'h1000;  // MOV A,0
    imem[5] = 16'h3020;  // LDA 0x20
    imem[6] = 16'hF800;  // HLT
    release_reset();
    cycles(8);
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'h20 || dmem_wdata !== 8'hA5) begin
      errors++; $display("FAIL sta_req: req=%b we=%b addr=%h wdata=%h expected 1/1/20/A5",
                         dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    cycles(2);
    checks++;
    if (dmem_req !== 1'b1 || dmem_wdata !== 8'hA5) begin
      errors++; $display("FAIL sta_wait_hold: req=%b wdata=%h expected 1/A5", dmem_req, dmem_wdata);
    end
    cycles(1);
    checks++;
    if (dmem_req !== 1'b0 || dmem[8'h20] !== 8'hA5) begin
      errors++; $display("FAIL sta_done: req=%b mem=%h expected 0/A5", dmem_req, dmem[8'h20]);
    end
    cycles(2);
    checks++;
    if (acc !== 8'h00) begin
      errors++; $display("FAIL mov_a_0: acc=%h expected 00", acc);
    end
    cycles(4);
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || acc !== 8'h00) begin
      errors++; $display("FAIL lda_wait: req=%b we=%b acc=%h expected 1/0/00", dmem_req, dmem_we, acc);
    end
    cycles(1);
    $display("LDA 0x20: acc=%h cy=%b z=%b", acc, cy, z);
    checks++;
    if (acc !== 8'hA5 || cy !== 1'b0 || z !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL lda_done: acc=%h cy=%b z=%b req=%b expected A5/0/1/0", acc, cy, z, dmem_req);
    end
  endtask

  task automatic test_alu_ops();
    logic [15:0] prog  [15];
    logic [7:0]  e_acc [14];
    logic        e_cy  [14];
    logic        e_z   [14];
    hold_reset();
    prog  = '{16'h090F, 16'h0AF0, 16'h1100, 16'h2204, 16'h2103, 16'h2105, 16'h2102,
              16'h2101, 16'h2106, 16'h2107, 16'h1B00, 16'h1100, 16'h1300, 16'h2100, 16'hF800};
    e_acc = '{8'h00, 8'h00, 8'h0F, 8'hFF, 8'h0F, 8'h00, 8'hF1,
              8'h01, 8'h01, 8'h02, 8'h02, 8'h0F, 8'h02, 8'h11};
    e_cy  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    e_z   = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) imem[i] = prog[i];
    release_reset();
    for (int k = 0; k < 14; k++) begin
      cycles(2);
      $display("instr %h: acc=%h cy=%b z=%b", prog[k], acc, cy, z);
      checks++;
      if (acc !== e_acc[k] || cy !== e_cy[k] || z !== e_z[k]) begin
        errors++; $display("FAIL alu_step[%0d]: acc=%h cy=%b z=%b expected %h/%b/%b",
                           k, acc, cy, z, e_acc[k], e_cy[k], e_z[k]);
      end
    end
  endtask

  task automatic test_jumps();
    hold_reset();
    imem[8'h00] = 16'h40FF;  // JMP 0xFF
    imem[8'hFF] = 16'h4880;  // JZ 0x80, z=0 so not taken
    release_reset();
    cycles(2);
    checks++;
    if (imem_addr !== 8'hFF) begin
      errors++; $display("FAIL jmp_taken: addr=%h expected FF", imem_addr);
    end
    cycles(2);
    checks++;
    if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin
      errors++; $display("FAIL pc_wrap_jz_not_taken: addr=%h req=%b expected 00/1", imem_addr, imem_req);
    end
    hold_reset();
    imem[0] = 16'h28FF;      // ADI 0xFF
    imem[1] = 16'h2801;      // ADI 0x01 -> cy=1
    imem[2] = 16'h5840;      // JC 0x40
    imem[8'h40] = 16'hF800;
    release_reset();
    cycles(4);
    checks++;
    if (acc !== 8'h00 || cy !== 1'b1 || z !== 1'b1) begin
      errors++; $display("FAIL pre_jc_flags: acc=%h cy=%b z=%b expected 00/1/1", acc, cy, z);
    end
    cycles(2);
    $display("JC 0x40: imem_addr=%h", imem_addr);
    checks++;
    if (imem_addr !== 8'h40 || imem_req !== 1'b1) begin
      errors++; $display("FAIL jc_taken: addr=%h req=%b expected 40/1", imem_addr, imem_req);
    end
  endtask

  task automatic test_illegal_halt();
    int req_seen;
    hold_reset();
    imem[0] = 16'h2833;  // ADI 0x33
    imem[1] = 16'hA800;  // opcode 10101
    imem[2] = 16'hF800;  // HLT
    release_reset();
    cycles(2);
    checks++;
    if (acc !== 8'h33 || illegal !== 1'b0) begin
      errors++; $display("FAIL pre_illegal: acc=%h illegal=%b expected 33/0", acc, illegal);
    end
    cycles(2);
    checks++;
    if (illegal !== 1'b1 || acc !== 8'h33 || cy !== 1'b0 || z !== 1'b0) begin
      errors++; $display("FAIL illegal_op: illegal=%b acc=%h cy=%b z=%b expected 1/33/0/0", illegal, acc, cy, z);
    end
    cycles(1);
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL halted_early: halted=%b expected 0", halted);
    end
    cycles(1);
    checks++;
    if (halted !== 1'b1 || illegal !== 1'b1) begin
      errors++; $display("FAIL halted: halted=%b illegal=%b expected 1/1", halted, illegal);
    end
    req_seen = 0;
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      if (imem_req !== 1'b0) req_seen++;
    end
    checks++;
    if (req_seen != 0) begin
      errors++; $display("FAIL halt_no_fetch: req cycles=%0d expected 0", req_seen);
    end
    hold_reset();
    release_reset();
    #1;
    checks++;
    if (illegal !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL halt_reset_exit: illegal=%b halted=%b req=%b expected 0/0/1", illegal, halted, imem_req);
    end
  endtask

  task automatic test_reset_mid_mem();
    hold_reset();
    dmem_wait = 5;
    imem[0] = 16'h2877;  // ADI 0x77
    imem[1] = 16'h3810;  // STA 0x10
    release_reset();
    cycles(5);
    checks++;
    if (dmem_req !== 1'b1 || acc !== 8'h77) begin
      errors++; $display("FAIL mem_wait_active: req=%b acc=%h expected 1/77", dmem_req, acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL async_req_drop: dmem_req=%b imem_req=%b expected 0/0", dmem_req, imem_req);
    end
    imem_wait = 0;
    release_reset();
    #1;
    checks++;
    if (imem_addr !== 8'h00 || imem_req !== 1'b1 || dmem_req !== 1'b0 || acc !== 8'h00 ||
        cy !== 1'b0 || z !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL post_reset_outputs: addr=%h ireq=%b dreq=%b acc=%h cy=%b z=%b h=%b ill=%b",
                         imem_addr, imem_req, dmem_req, acc, cy, z, halted, illegal);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_sta_lda();
    test_alu_ops();
    test_jumps();
    test_illegal_halt();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
